// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU among NUM_REQ requesters: grant, S1 issue register, S2 result tag.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module alu_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [2*NUM_REQ-1:0]           req_arith_mux,
  input  logic [NUM_REQ-1:0]             req_output_mux,
  input  logic [DATA_BITS*NUM_REQ-1:0]   req_rs,
  input  logic [DATA_BITS*NUM_REQ-1:0]   req_rt,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [DATA_BITS-1:0]           resp_data,
  output logic                           alu_enable,
  output logic [2:0]                     alu_core_state,
  output logic [1:0]                     alu_arithmetic_mux,
  output logic                           alu_output_mux,
  output logic [DATA_BITS-1:0]           alu_rs,
  output logic [DATA_BITS-1:0]           alu_rt,
  input  logic [DATA_BITS-1:0]           alu_out,
  output logic                           busy,
  output logic [15:0]                    grant_count
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic                 found;
  logic                 accept;
  logic [ID_W-1:0]      gid;
  logic [ID_W-1:0]      scan_base;

  logic                 vld_p1;
  logic [ID_W-1:0]      id_p1;
  logic [1:0]           arith_p1;
  logic                 omux_p1;
  logic [DATA_BITS-1:0] rs_p1;
  logic [DATA_BITS-1:0] rt_p1;
  logic                 vld_p2;
  logic [ID_W-1:0]      id_p2;
  logic [15:0]          count;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef ALU_ARB_RR_EN
  logic [ID_W-1:0] ptr;
  assign scan_base = ptr;
`else
  assign scan_base = '0;
`endif

  // Grant: scan from scan_base (0 in fixed-priority builds), first valid requester wins
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gid   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(scan_base) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gid   = ID_W'(idx);
      end
    end
  end

  assign accept    = found & enable & ~reset;
  assign req_ready = accept ? (NUM_REQ'(1) << gid) : '0;

  // ---- S1 issue / S2 result stage boundaries ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      id_p1    <= '0;
      arith_p1 <= '0;
      omux_p1  <= 1'b0;
      rs_p1    <= '0;
      rt_p1    <= '0;
      vld_p2   <= 1'b0;
      id_p2    <= '0;
      count    <= '0;
`ifdef ALU_ARB_RR_EN
      ptr      <= '0;
`endif
    end else begin
      vld_p1 <= accept;
      if (accept) begin
        id_p1    <= gid;
        arith_p1 <= req_arith_mux[2*gid +: 2];
        omux_p1  <= req_output_mux[gid];
        rs_p1    <= req_rs[DATA_BITS*gid +: DATA_BITS];
        rt_p1    <= req_rt[DATA_BITS*gid +: DATA_BITS];
        count    <= sat_inc(count);
`ifdef ALU_ARB_RR_EN
        ptr      <= (gid == ID_W'(NUM_REQ-1)) ? '0 : gid + ID_W'(1);
`endif
      end
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
    end
  end

  // S1 operands stay put between grants, so the ALU inputs hold while idle
  assign alu_enable         = vld_p1;
  assign alu_core_state     = vld_p1 ? 3'b101 : 3'b000;
  assign alu_arithmetic_mux = arith_p1;
  assign alu_output_mux     = omux_p1;
  assign alu_rs             = rs_p1;
  assign alu_rt             = rt_p1;

  assign resp_valid  = vld_p2 ? (NUM_REQ'(1) << id_p2) : '0;
  assign resp_data   = alu_out;
  assign busy        = vld_p1 | vld_p2;
  assign grant_count = count;

endmodule
